// File: rtl/cache_arb_pkg.sv
// Shared types for the cache bus arbiter: FSM states, grant encoding and the
// SRAM-like request bundle used by both caches.
package cache_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 32;
  localparam int unsigned SRAM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;

  typedef enum logic {GNT_INST, GNT_DATA} arb_grant_t;

  typedef struct packed {
    logic                   req;
    logic                   wr;
    logic [1:0]             size;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin pick. req[0] is the I-cache, req[1] the
// D-cache; on a tie the requester that was not served last wins.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      winner = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one SRAM-like memory port between the I-cache and D-cache with
// round-robin fairness and a single outstanding transaction.
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  arb_state_t state_q, state_d;
  arb_grant_t grant_q, grant_d;
  arb_grant_t last_grant_q, last_grant_d;

  logic arb_winner;
  logic arb_valid;
  logic sel_data;
  logic win_req;
  logic addr_hs;
  logic data_hs;

  rr_arb2 u_rr_arb2 (
    .req        ({data_req, inst_req}),
    .last_grant (last_grant_q),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  assign sel_data = (grant_q == GNT_DATA);
  assign win_req  = sel_data ? data_req : inst_req;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Handshakes are gated by rst so a reset cycle never leaks an ok to a cache.
  always_comb begin
    mem_wr    = sel_data ? data_wr    : inst_wr;
    mem_size  = sel_data ? data_size  : inst_size;
    mem_addr  = sel_data ? data_addr  : inst_addr;
    mem_wdata = sel_data ? data_wdata : inst_wdata;

    mem_req = !rst && (state_q == ADDR) && win_req;
    addr_hs = mem_req && mem_addr_ok;
    data_hs = !rst && (state_q == DATA) && mem_data_ok;

    inst_addr_ok = addr_hs && !sel_data;
    data_addr_ok = addr_hs &&  sel_data;
    inst_data_ok = data_hs && !sel_data;
    data_data_ok = data_hs &&  sel_data;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ADDR;
          grant_d = arb_grant_t'(arb_winner);
        end
      end
      ADDR: begin
        if (addr_hs) begin
          state_d = DATA;
        end else if (!win_req) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (data_hs) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_INST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: table-driven single transactions
// plus hand-written contention, stall, reset and spurious-handshake sequences.
module tb_cache_bus_arbiter;
  import cache_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_addr_ok = 0, mem_data_ok = 0;

  int tests = 0;
  int fails = 0;

  cache_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        who;   // 0 = I-cache, 1 = D-cache
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        i_wr;
    logic [1:0]  i_size;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    int          stall;
    logic        who;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic who, input logic wr, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
    exp_t e;
    e.who = who; e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endfunction

  task automatic check_no_ok(input string name);
    check(name, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check_no_ok("rst_ok");
    check("rst_state", dut.state_q, IDLE);
    check("rst_grant", dut.grant_q, GNT_INST);
    check("rst_last_grant", dut.last_grant_q, GNT_INST);
    rst = 0;
  endtask

  // Plays the memory side of one transaction, checking against the scoreboard head.
  task automatic serve(input int stall, output int waited);
    exp_t e;
    int   n;
    bit   seen;
    waited = -1;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      if (mem_req) seen = 1;
      else n++;
    end
    waited = n;
    if (!seen) begin
      check("mem_req_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, e.addr);
      check_no_ok("stall_ok");
      @(negedge clk); #1;
    end
    mem_addr_ok = 1; #1;
    check("mem_addr", mem_addr, e.addr);
    check("mem_wr", mem_wr, e.wr);
    check("mem_size", mem_size, e.size);
    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
    check("addr_ok", {inst_addr_ok, data_addr_ok}, e.who ? 2'b01 : 2'b10);
    check("early_data_ok", {inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = e.rdata; #1;
    check("data_ok", {inst_data_ok, data_data_ok}, e.who ? 2'b01 : 2'b10);
    check("addr_ok_in_data", {inst_addr_ok, data_addr_ok}, 0);
    check("rdata", e.who ? data_rdata : inst_rdata, e.rdata);
    check("mem_req_in_data", mem_req, 0);
    @(negedge clk);
    mem_data_ok = 0; #1;
    check("idle_gap", mem_req, 0);
  endtask

  task automatic drive_bundles(input vec_t v);
    inst_req = v.i_req; inst_wr = v.i_wr; inst_size = v.i_size;
    inst_addr = v.i_addr; inst_wdata = v.i_wdata;
    data_req = v.d_req; data_wr = v.d_wr; data_size = v.d_size;
    data_addr = v.d_addr; data_wdata = v.d_wdata;
  endtask

  initial begin
    int w;
    vec_t v;

    //            ireq dreq iwr isz   iaddr         iwdata        dwr dsz   daddr         dwdata        rdata         st who
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        1'b0, 2'd2, 32'h0,        32'h0,        32'h24020001, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0,        32'h0,        1'b1, 2'd0, 32'h80000020, 32'h000000A5, 32'h0,        1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h00000200, 32'h0,        1'b1, 2'd1, 32'h80000040, 32'h0000BEEF, 32'h11112222, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h00000300, 32'h0,        1'b0, 2'd2, 32'h80000080, 32'h0,        32'h33334444, 2, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h00000400, 32'hCAFEF00D, 1'b0, 2'd2, 32'h0,        32'h0,        32'h55556666, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0,        32'h0,        1'b0, 2'd2, 32'h9000000C, 32'h0,        32'h77778888, 3, 1'b1};

    do_reset();

    // Simultaneous requests straight after reset: D first, then I.
    inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h100;
    data_wr = 1; data_size = 2'd2; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    inst_req = 1; data_req = 1;
    push_exp(1'b1, 1'b1, 2'd2, 32'h80000010, 32'hDEADBEEF, 32'h0);
    push_exp(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0BADF00D);
    serve(0, w); check("sim_d_latency", w, 0);
    data_req = 0;
    serve(0, w); check("sim_i_latency", w, 0);
    inst_req = 0;

    // Table of single transactions; the winner is served, the loser then withdraws.
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      @(negedge clk);
      drive_bundles(v);
      if (v.who) push_exp(1'b1, v.d_wr, v.d_size, v.d_addr, v.d_wdata, v.rdata);
      else       push_exp(1'b0, v.i_wr, v.i_size, v.i_addr, v.i_wdata, v.rdata);
      serve(v.stall, w);
      check("vec_latency", w, 0);
      inst_req = 0; data_req = 0;
      @(negedge clk); #1;
      check("vec_idle_req", mem_req, 0);
      check("vec_idle_state", dut.state_q, IDLE);
    end

    // Continuous contention: grants alternate D, I, D, I, ...
    do_reset();
    inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h00000100;
    data_wr = 1; data_size = 2'd2; data_addr = 32'h00002000; data_wdata = 32'h12345678;
    inst_req = 1; data_req = 1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push_exp(1'b1, 1'b1, 2'd2, 32'h00002000, 32'h12345678, 32'h0);
      else            push_exp(1'b0, 1'b0, 2'd2, 32'h00000100, 32'h0, 32'hA0000000 + 32'(k));
    end
    for (int k = 0; k < 8; k++) begin
      serve(0, w);
      check("rr_latency", w, 0);
    end
    inst_req = 0; data_req = 0;

    // Address stall while granted to I, D arriving mid-stall.
    @(negedge clk);
    inst_addr = 32'h00000500; inst_wr = 0;
    data_addr = 32'h80000500; data_wr = 0;
    push_exp(1'b0, 1'b0, 2'd2, 32'h00000500, 32'h0, 32'h5A5A5A5A);
    push_exp(1'b1, 1'b0, 2'd2, 32'h80000500, 32'h0, 32'hA5A5A5A5);
    inst_req = 1;
    @(posedge clk); #1;
    data_req = 1;
    serve(5, w); check("stall_i_latency", w, 0);
    inst_req = 0;
    serve(0, w); check("stall_d_latency", w, 0);
    data_req = 0;

    // Reset in DATA while mem_data_ok arrives: no handshake may leak.
    @(negedge clk);
    inst_addr = 32'h00000600; inst_req = 1;
    @(negedge clk); #1;
    check("rstd_mem_req", mem_req, 1);
    mem_addr_ok = 1;
    @(negedge clk);
    mem_addr_ok = 0; inst_req = 0;
    rst = 1; mem_data_ok = 1; #1;
    check("rstd_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("rstd_mem_req_rst", mem_req, 0);
    @(negedge clk);
    rst = 0; mem_data_ok = 0; #1;
    check("rstd_mem_req_after", mem_req, 0);
    check_no_ok("rstd_ok_after");
    check("rstd_state", dut.state_q, IDLE);
    check("rstd_last_grant", dut.last_grant_q, GNT_INST);

    // Spurious handshakes: both in IDLE, then addr_ok in DATA.
    mem_addr_ok = 1; mem_data_ok = 1; #1;
    check_no_ok("spur_idle_ok");
    @(negedge clk); #1;
    check("spur_idle_state", dut.state_q, IDLE);
    check_no_ok("spur_idle_ok2");
    mem_addr_ok = 0; mem_data_ok = 0;
    data_addr = 32'h80000700; data_req = 1;
    @(negedge clk);
    mem_addr_ok = 1; #1;
    check("spur_addr_ok", data_addr_ok, 1);
    @(negedge clk);
    data_req = 0; #1;
    check_no_ok("spur_data_ok");
    check("spur_in_data_state", dut.state_q, DATA);
    @(negedge clk); #1;
    check("spur_data_state", dut.state_q, DATA);
    mem_addr_ok = 0; mem_data_ok = 1; #1;
    check("spur_final_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
    @(negedge clk);
    mem_data_ok = 0; #1;
    check("spur_final_state", dut.state_q, IDLE);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
